// File: rtl/receptor_serial_pkg.sv
// Shared types and defaults for the serial receiver.
package receptor_serial_pkg;

    localparam int unsigned RX_WIDTH = 32;

    // Receive FSM encodings (2 bits)
    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_SHIFT  = 2'd1,
        RX_PARITY = 2'd2
    } rx_state_t;

endpackage

// File: rtl/receptor_serial_if.sv
// Serial input side and parallel word output side of the receiver.
interface receptor_serial_if
    import receptor_serial_pkg::*;
#(
    parameter int unsigned WIDTH = RX_WIDTH
) ();

    logic             enb;
    logic             s_in;
    logic             s_valid;
    logic             dir;
    logic [WIDTH-1:0] q;
    logic             q_par_err;
    logic             q_valid;
    logic             q_ready;
    logic             busy;
    logic             overrun;

    modport master (
        output enb, s_in, s_valid, dir, q_ready,
        input  q, q_par_err, q_valid, busy, overrun
    );

    modport slave (
        input  enb, s_in, s_valid, dir, q_ready,
        output q, q_par_err, q_valid, busy, overrun
    );

endinterface

// File: rtl/receptor_serial_fifo_salida.sv
// Two-entry output FIFO; entry 0 is always the head so the head is a register.
module fifo_salida #(
    parameter int unsigned W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    logic [W-1:0] mem0;
    logic [W-1:0] mem1;
    logic         v0;
    logic         v1;
    logic         pop_eff_c;
    logic         push_eff_c;

    assign pop_eff_c  = pop & v0;
    assign push_eff_c = push & (~v1 | pop_eff_c);

    // Shift-style storage; unused entries are kept at zero so the head reads 0 when empty
    always_ff @(posedge clk) begin
        if (rst) begin
            mem0 <= '0;
            mem1 <= '0;
            v0   <= 1'b0;
            v1   <= 1'b0;
        end else if (pop_eff_c) begin
            if (push_eff_c) begin
                if (v1) begin
                    mem0 <= mem1;
                    mem1 <= din;
                end else begin
                    mem0 <= din;
                end
            end else begin
                mem0 <= mem1;
                v0   <= v1;
                mem1 <= '0;
                v1   <= 1'b0;
            end
        end else if (push_eff_c) begin
            if (!v0) begin
                mem0 <= din;
                v0   <= 1'b1;
            end else begin
                mem1 <= din;
                v1   <= 1'b1;
            end
        end
    end

    assign full  = v1;
    assign empty = ~v0;
    assign head  = mem0;

endmodule

// File: rtl/receptor_serial.sv
// Serial-to-parallel receiver with optional even parity and a 2-entry output FIFO.
module receptor_serial
    import receptor_serial_pkg::*;
#(
    parameter int unsigned WIDTH  = RX_WIDTH,
    parameter bit          PAR_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    receptor_serial_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned FW    = WIDTH + 1;

    rx_state_t        state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] sh;
    logic             dir_q;
    logic             busy;
    logic             overrun;

    logic             accept_c;
    logic             dir_sel_c;
    logic [WIDTH-1:0] sh_next_c;
    logic             last_data_c;
    logic             push_c;
    logic             pop_c;
    logic [FW-1:0]    push_data_c;
    logic             full;
    logic             empty;
    logic [FW-1:0]    head;

    // Bit qualification, shift candidate and word-complete decode
    always_comb begin
        accept_c    = bus.enb & bus.s_valid;
        dir_sel_c   = (state == RX_IDLE) ? bus.dir : dir_q;
        sh_next_c   = dir_sel_c ? {bus.s_in, sh[WIDTH-1:1]} : {sh[WIDTH-2:0], bus.s_in};
        last_data_c = accept_c && (state == RX_SHIFT) && (count == CNT_W'(WIDTH - 1));
        push_c      = accept_c && ((state == RX_PARITY) || (last_data_c && !PAR_EN));
        push_data_c = (state == RX_PARITY) ? {(^sh) ^ bus.s_in, sh} : {1'b0, sh_next_c};
        pop_c       = ~empty & bus.q_ready;
    end

    // Receive FSM, bit counter, shift register and sticky overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RX_IDLE;
            count   <= '0;
            sh      <= '0;
            dir_q   <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (push_c && full && !pop_c) begin
                overrun <= 1'b1;
            end
            if (accept_c) begin
                case (state)
                    RX_IDLE: begin
                        state <= RX_SHIFT;
                        busy  <= 1'b1;
                        count <= CNT_W'(1);
                        dir_q <= bus.dir;
                        sh    <= sh_next_c;
                    end
                    RX_SHIFT: begin
                        sh <= sh_next_c;
                        if (last_data_c) begin
                            if (PAR_EN) begin
                                state <= RX_PARITY;
                                count <= CNT_W'(WIDTH);
                            end else begin
                                state <= RX_IDLE;
                                busy  <= 1'b0;
                                count <= '0;
                            end
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                    RX_PARITY: begin
                        state <= RX_IDLE;
                        busy  <= 1'b0;
                        count <= '0;
                    end
                    default: begin
                        state <= RX_IDLE;
                        busy  <= 1'b0;
                        count <= '0;
                    end
                endcase
            end
        end
    end

    fifo_salida #(.W(FW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .pop   (pop_c),
        .din   (push_data_c),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    assign bus.q         = head[WIDTH-1:0];
    assign bus.q_par_err = head[WIDTH];
    assign bus.q_valid   = ~empty;
    assign bus.busy      = busy;
    assign bus.overrun   = overrun;

endmodule

// File: tb/tb_receptor_serial.sv
// Directed bench for receptor_serial with a scoreboard of expected {err, word}.
module tb_receptor_serial;
    import receptor_serial_pkg::*;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    receptor_serial_if #(.WIDTH(W)) bus0 ();
    receptor_serial_if #(.WIDTH(W)) bus1 ();

    receptor_serial #(.WIDTH(W), .PAR_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    receptor_serial #(.WIDTH(W), .PAR_EN(1'b0)) dut_np (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    logic [W:0] exp_q[$];
    int total  = 0;
    int passes = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare the head word on every handshake beat; head must be 0 when empty
    always @(negedge clk) begin
        if (!rst) begin
            if (bus0.q_valid && bus0.q_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    fails++;
                    $error("FAIL unexpected_word observed=%h expected=none", {bus0.q_par_err, bus0.q});
                end else begin
                    chk("word", {bus0.q_par_err, bus0.q}, exp_q.pop_front());
                end
            end else if (!bus0.q_valid) begin
                chk("idle_zero", {bus0.q_par_err, bus0.q}, '0);
            end
        end
    end

    task automatic send_bit(input logic b, input bit gaps);
        if (gaps) begin
            int n = int'($urandom_range(0, 3));
            for (int k = 0; k < n; k++) begin
                bus0.enb     = 1'($urandom_range(0, 1));
                bus0.s_valid = bus0.enb ? 1'b0 : 1'($urandom_range(0, 1));
                bus0.s_in    = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
        end
        bus0.enb     = 1'b1;
        bus0.s_valid = 1'b1;
        bus0.s_in    = b;
        @(posedge clk); #1;
        bus0.s_valid = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic d, input logic par,
                             input bit keep, input bit gaps, input bit rdy_last);
        logic [W-1:0] t;
        t = w;
        if (keep) exp_q.push_back({(^w) ^ par, w});
        bus0.dir = d;
        for (int i = 0; i < W; i++) begin
            send_bit(d ? t[i] : t[W-1-i], gaps);
            if (gaps && i == 0) bus0.dir = ~d;
        end
        if (rdy_last) bus0.q_ready = 1'b1;
        send_bit(par, gaps);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        bus0.q_ready = 1'b1;
        while ((exp_q.size() != 0 || bus0.q_valid) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_sb_empty"}, (W+1)'(exp_q.size()), '0);
        chk({tag, "_valid_low"}, (W+1)'(bus0.q_valid), '0);
    endtask

    task automatic do_reset();
        bus0.enb     = 1'b1;
        bus0.s_valid = 1'b1;
        bus0.s_in    = 1'b1;
        rst          = 1'b1;
        @(posedge clk); #1;
        rst          = 1'b0;
        bus0.s_valid = 1'b0;
    endtask

    initial begin
        logic [W-1:0] lb_reg;
        logic [W-1:0] t;
        bus0.enb = 1'b0; bus0.s_in = 1'b0; bus0.s_valid = 1'b0; bus0.dir = 1'b0; bus0.q_ready = 1'b0;
        bus1.enb = 1'b0; bus1.s_in = 1'b0; bus1.s_valid = 1'b0; bus1.dir = 1'b0; bus1.q_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_flags", (W+1)'({bus0.overrun, bus0.busy, bus0.q_valid}), '0);
        chk("rst_q", {bus0.q_par_err, bus0.q}, '0);

        // 1: MSB-first word with latency and BUSY checks
        t = 32'hDDDDDDDD;
        bus0.dir = 1'b0;
        exp_q.push_back({1'b0, t});
        for (int i = 0; i < W; i++) begin
            send_bit(t[W-1-i], 1'b0);
            if (i == 0)     chk("t1_busy_first", (W+1)'(bus0.busy), (W+1)'(1));
            if (i == W - 1) chk("t1_busy_last_data", (W+1)'(bus0.busy), (W+1)'(1));
        end
        chk("t1_valid_before_parity", (W+1)'(bus0.q_valid), '0);
        send_bit(1'b0, 1'b0);
        chk("t1_valid_after_parity", (W+1)'(bus0.q_valid), (W+1)'(1));
        chk("t1_busy_after", (W+1)'(bus0.busy), '0);
        chk("t1_head", {bus0.q_par_err, bus0.q}, {1'b0, 32'hDDDDDDDD});
        drain("t1");

        // 2: LSB-first word with parity error
        send_word(32'hAAAAAAAA, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drain("t2");

        // 3: third word overflows a full FIFO
        bus0.q_ready = 1'b0;
        send_word(32'h1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        send_word(32'h2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t3_overrun_before", (W+1)'(bus0.overrun), '0);
        send_word(32'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_overrun_after", (W+1)'(bus0.overrun), (W+1)'(1));
        drain("t3");
        chk("t3_overrun_sticky", (W+1)'(bus0.overrun), (W+1)'(1));

        // 4: push and pop on the same edge while full
        do_reset();
        chk("t4_rst_overrun", (W+1)'(bus0.overrun), '0);
        bus0.q_ready = 1'b0;
        send_word(32'h1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        send_word(32'h2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        send_word(32'h3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("t4_overrun", (W+1)'(bus0.overrun), '0);
        drain("t4");

        // 5: reset discards a partial word
        t = 32'h12345678;
        bus0.dir = 1'b0;
        for (int i = 0; i < 10; i++) send_bit(t[W-1-i], 1'b0);
        chk("t5_busy_partial", (W+1)'(bus0.busy), (W+1)'(1));
        do_reset();
        chk("t5_busy_reset", (W+1)'(bus0.busy), '0);
        send_word(32'h66666666, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drain("t5");
        chk("t5_busy_end", (W+1)'(bus0.busy), '0);

        // 6: gaps, mid-word DIR toggles and back-to-back words
        bus0.q_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            t = $urandom;
            send_word(t, 1'(k), 1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b1);
        end
        send_word(32'hCAFEF00D, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        send_word(32'h0F0F1234, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        drain("t6");
        chk("t6_overrun", (W+1)'(bus0.overrun), '0);

        // 6b: loopback from a 32-bit left-shifting register into the no-parity instance
        lb_reg = 32'hDDDDDDDD;
        bus1.dir = 1'b0;
        bus1.enb = 1'b1;
        bus1.s_valid = 1'b1;
        for (int i = 0; i < W; i++) begin
            bus1.s_in = lb_reg[W-1];
            lb_reg = {lb_reg[W-2:0], 1'b0};
            @(posedge clk); #1;
        end
        bus1.s_valid = 1'b0;
        chk("lb_valid", (W+1)'(bus1.q_valid), (W+1)'(1));
        chk("lb_word", {bus1.q_par_err, bus1.q}, {1'b0, 32'hDDDDDDDD});
        chk("lb_busy", (W+1)'(bus1.busy), '0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
